capp_cell_array_p: RTL and testbench
====================================

Name: capp_cell_array_p

Overview:
- Parametrised content-addressable parallel-processor cell array: DEPTH words of WIDTH bits, each with a one-bit tag (responder) register.
- Accepts one command per cycle over a valid/ready handshake: masked search, masked parallel write to tagged cells, wired-OR read, and responder resolution.
- Returns one registered response per accepted command over a second valid/ready handshake.
- Sits between the CAPP sequencer/controller and the cell storage. It replaces the fixed 100x32 array with mismatch-line encoding and adds an internal tag register, tag-combine modes and priority resolution.

Parameters:
WIDTH, 32, bits per cell word
DEPTH, 100, number of cells (>=2)
IDXW, $clog2(DEPTH), width of cell index

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_op  input  3  opcode (see Behaviour)
cmd_key  input  WIDTH  comparand / write data
cmd_mask  input  WIDTH  bit-select mask; 1 = bit participates
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_data  output  WIDTH  read result (0 for non-READ ops)
rsp_any  output  1  at least one tag set after the op
rsp_first  output  IDXW  lowest set tag index after the op (0 if none)
tags  output  DEPTH  current tag register

Behaviour:
- Reset (async, RST_N=0): all store words = 0, tags = 0, rsp_valid = 0, rsp_data = 0, rsp_any = 0, rsp_first = 0. Reset mid-command discards the command and any pending response. cmd_ready is 1 once reset has deasserted.
- Reset level: cmd_ready = !rsp_valid | rsp_ready, combinational. The response register is single-entry, so a back-to-back command is accepted in the same cycle the old response is consumed.
- Match definition: cell i matches when ((store[i] ^ cmd_key) & cmd_mask) == 0. A mask of 0 matches every cell.
- All operations execute in the acceptance cycle on pre-edge state. Results (store, tags, response) are visible after that edge. Response latency is exactly 1 cycle.
- Opcodes:
  - 0 NOP: no state change; a response is still produced.
  - 1 SEARCH_SET: tags <= match vector.
  - 2 SEARCH_AND: tags <= tags & match.
  - 3 WRITE: for each tagged i, store[i] <= (store[i] & ~cmd_mask) | (cmd_key & cmd_mask). Untagged cells are unchanged. Tags are unchanged.
  - 4 READ: rsp_data <= OR over i of (store[i] & {WIDTH{tags[i]}}). Returns 0 if no tags are set. Tags are unchanged.
  - 5 SELECT_FIRST: tags <= one-hot of the lowest set tag. Stays 0 if tags are 0.
  - 6 SET_ALL: tags <= all ones.
  - 7 CLEAR_FIRST: clears the lowest set tag. This is a responder-iteration step; it is a no-op if tags are 0.
- rsp_any and rsp_first reflect the post-op tag vector. Lowest index has priority.
- Response hold: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs are held stable and cmd_ready=0. No state changes.
- When no command is accepted and the response is consumed, rsp_valid <= 0 and rsp_data/rsp_any/rsp_first hold their last values.
- Tags are only modified by opcodes 1, 2, 5, 6, 7. Store is only modified by opcode 3.
- The priority encoder and OR-reduce are combinational over DEPTH. No multi-cycle paths are allowed.

Test Plan:
- Reset: WIDTH=8, DEPTH=4. Assert RST_N=0 mid-command with rsp_valid pending -> all outputs 0, tags=4'b0000, pending response dropped. After release, READ with SET_ALL returns rsp_data=0.
- Write/read: SET_ALL, then WRITE key=8'hA5 mask=8'hFF -> every cell holds A5. SEARCH_SET key=8'h05 mask=8'h0F -> tags=4'b1111. READ -> rsp_data=8'hA5, rsp_any=1, rsp_first=0.
- Masked search and partial write:
  - Setup: cells loaded 8'h10, 8'h21, 8'h12, 8'h33 using SELECT_FIRST/CLEAR_FIRST iteration.
  - SEARCH_SET key=8'h02 mask=8'h0F -> tags=4'b0100, rsp_first=2.
  - WRITE key=8'hF0 mask=8'hF0 -> cell2=8'hF2, others unchanged.
- Tag combine and resolution:
  - SEARCH_SET key=8'h00 mask=8'h01 -> tags=4'b0101.
  - SEARCH_AND key=8'h10 mask=8'hF0 -> tags=4'b0001.
  - SET_ALL, then SELECT_FIRST -> 4'b0001.
  - CLEAR_FIRST -> 4'b0000, rsp_any=0, rsp_first=0.
  - CLEAR_FIRST again -> still 0.
- Wired-OR read: tags=4'b1010 with cells 8'h21 and 8'h33 -> READ rsp_data=8'h33.
- Backpressure: issue 3 commands back-to-back with rsp_ready low for 4 cycles.
  - cmd_ready=0 and rsp_* stable throughout the stall.
  - Second command accepted in the same cycle rsp_ready rises.
  - Responses arrive in order with no loss or duplication.

Source files
------------

// File: rtl/capp_cell_array_p.sv
// Content-addressable parallel-processor cell array: masked search, masked write to
// tagged cells, wired-OR read and lowest-index responder resolution, one op per cycle.

module capp_cell_p #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             we_i,
   input  logic [WIDTH-1:0] key_i,
   input  logic [WIDTH-1:0] mask_i,
   output logic [WIDTH-1:0] word_o,
   output logic             match_o
);
   logic [WIDTH-1:0] word_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) word_q <= '0;
      else if (we_i) word_q <= (word_q & ~mask_i) | (key_i & mask_i);
   end

   assign word_o  = word_q;
   assign match_o = ((word_q ^ key_i) & mask_i) == '0;
endmodule

module capp_cell_array_p #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 100,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_key,
   input  logic [WIDTH-1:0] cmd_mask,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_any,
   output logic [IDXW-1:0]  rsp_first,
   output logic [DEPTH-1:0] tags
);
   localparam logic [2:0] OP_SEARCH_SET = 3'd1, OP_SEARCH_AND = 3'd2, OP_WRITE = 3'd3,
                          OP_READ = 3'd4, OP_SELECT_FIRST = 3'd5, OP_SET_ALL = 3'd6,
                          OP_CLEAR_FIRST = 3'd7;

   logic [DEPTH-1:0]            tags_q, tags_d, match, first_oh;
   logic [DEPTH-1:0][WIDTH-1:0] words;
   logic [WIDTH-1:0]            read_or, rsp_data_q;
   logic [IDXW-1:0]             first_d, rsp_first_q;
   logic                        rsp_valid_q, rsp_any_q, accept;

   assign cmd_ready = !rsp_valid_q | rsp_ready;
   assign accept    = cmd_valid & cmd_ready;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      capp_cell_p #(.WIDTH(WIDTH)) u_cell (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .we_i    (accept && (cmd_op == OP_WRITE) && tags_q[g]),
         .key_i   (cmd_key),
         .mask_i  (cmd_mask),
         .word_o  (words[g]),
         .match_o (match[g])
      );
   end

   // Isolate the lowest set tag: x & -x.
   assign first_oh = tags_q & (~tags_q + DEPTH'(1));

   always_comb begin
      read_or = '0;
      for (int i = 0; i < DEPTH; i++)
         if (tags_q[i]) read_or = read_or | words[i];
   end

   always_comb begin
      tags_d = tags_q;
      if (accept) begin
         case (cmd_op)
            OP_SEARCH_SET:   tags_d = match;
            OP_SEARCH_AND:   tags_d = tags_q & match;
            OP_SELECT_FIRST: tags_d = first_oh;
            OP_SET_ALL:      tags_d = '1;
            OP_CLEAR_FIRST:  tags_d = tags_q & ~first_oh;
            default:         tags_d = tags_q;
         endcase
      end
   end

   // Descending scan so the lowest set index wins.
   always_comb begin
      first_d = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (tags_d[i]) first_d = IDXW'(i);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tags_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_any_q   <= 1'b0;
         rsp_first_q <= '0;
      end else begin
         tags_q <= tags_d;
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (cmd_op == OP_READ) ? read_or : '0;
            rsp_any_q   <= |tags_d;
            rsp_first_q <= first_d;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_any   = rsp_any_q;
   assign rsp_first = rsp_first_q;
   assign tags      = tags_q;
endmodule

// File: tb/tb_capp_cell_array_p.sv
// Bench for capp_cell_array_p (WIDTH=8, DEPTH=4): directed table, backpressure and
// reset sequences, then randomized commands against an array-based reference model.

module tb_capp_cell_array_p;
   logic       CLK = 1'b0, RST_N = 1'b0;
   logic       cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_any;
   logic [2:0] cmd_op = '0;
   logic [7:0] cmd_key = '0, cmd_mask = '0, rsp_data;
   logic [1:0] rsp_first;
   logic [3:0] tags;

   capp_cell_array_p #(.WIDTH(8), .DEPTH(4)) dut (
      .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_mask(cmd_mask), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_any(rsp_any),
      .rsp_first(rsp_first), .tags(tags)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] op;
      logic [7:0] key, mask, data;
      logic [3:0] tags;
      logic       any;
      logic [1:0] first;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] tags;
      logic       any;
      logic [1:0] first;
   } exp_t;

   int checks = 0, failures = 0;
   logic [7:0] mstore[4];
   logic [3:0] mtags;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [3:0] t);
      for (int i = 0; i < 4; i++) if (t[i]) return i;
      return -1;
   endfunction

   // Reference: apply one op to the model arrays and return the expected response.
   task automatic model(input logic [2:0] op, input logic [7:0] key, input logic [7:0] mask,
                        output exp_t e);
      logic [3:0] m;
      int k;
      for (int i = 0; i < 4; i++) m[i] = ((mstore[i] ^ key) & mask) == 8'h00;
      k = lowest(mtags);
      e.data = 8'h00;
      case (op)
         3'd1: mtags = m;
         3'd2: mtags = mtags & m;
         3'd3: for (int i = 0; i < 4; i++)
                  if (mtags[i]) mstore[i] = (mstore[i] & ~mask) | (key & mask);
         3'd4: for (int i = 0; i < 4; i++) if (mtags[i]) e.data = e.data | mstore[i];
         3'd5: mtags = (k < 0) ? 4'b0000 : 4'(1 << k);
         3'd6: mtags = 4'b1111;
         3'd7: if (k >= 0) mtags[k] = 1'b0;
         default: ;
      endcase
      e.tags  = mtags;
      e.any   = |mtags;
      e.first = (lowest(mtags) < 0) ? 2'd0 : 2'(lowest(mtags));
   endtask

   task automatic chk_rsp(input string nm, input exp_t e);
      chk({nm, ".valid"}, rsp_valid, 1);
      chk({nm, ".data"}, rsp_data, e.data);
      chk({nm, ".tags"}, tags, e.tags);
      chk({nm, ".any"}, rsp_any, e.any);
      chk({nm, ".first"}, rsp_first, e.first);
   endtask

   // One command; response held for 'stall' cycles with rsp_ready low, then consumed.
   task automatic send(input string nm, input logic [2:0] op, input logic [7:0] key,
                       input logic [7:0] mask, input int stall, input exp_t e);
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_mask = mask; rsp_ready = 1'b0;
      chk({nm, ".cmd_ready"}, cmd_ready, 1);
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk_rsp(nm, e);
      for (int s = 0; s < stall; s++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk({nm, ".stall_ready"}, cmd_ready, 0);
         chk_rsp({nm, ".stall"}, e);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
   endtask

   function automatic vec_t v(input logic [2:0] op, input logic [7:0] key, input logic [7:0] mask,
                              input logic [7:0] data, input logic [3:0] t, input logic [1:0] f);
      vec_t r;
      r.op = op; r.key = key; r.mask = mask; r.data = data; r.tags = t; r.any = |t; r.first = f;
      return r;
   endfunction

   initial begin
      vec_t tbl[$];
      exp_t e, ea, eb, ec;
      logic [2:0] op;
      logic [7:0] key, mask;

      tbl.push_back(v(6, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(4, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(3, 8'hA5, 8'hFF, 8'h00, 4'b1111, 0));
      tbl.push_back(v(1, 8'h05, 8'h0F, 8'h00, 4'b1111, 0));
      tbl.push_back(v(4, 8'h00, 8'h00, 8'hA5, 4'b1111, 0));
      // load 10,21,12,33 by responder iteration
      tbl.push_back(v(5, 8'h00, 8'h00, 8'h00, 4'b0001, 0));
      tbl.push_back(v(3, 8'h10, 8'hFF, 8'h00, 4'b0001, 0));
      tbl.push_back(v(6, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1110, 1));
      tbl.push_back(v(5, 8'h00, 8'h00, 8'h00, 4'b0010, 1));
      tbl.push_back(v(3, 8'h21, 8'hFF, 8'h00, 4'b0010, 1));
      tbl.push_back(v(6, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1110, 1));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1100, 2));
      tbl.push_back(v(5, 8'h00, 8'h00, 8'h00, 4'b0100, 2));
      tbl.push_back(v(3, 8'h12, 8'hFF, 8'h00, 4'b0100, 2));
      tbl.push_back(v(6, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1110, 1));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1100, 2));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b1000, 3));
      tbl.push_back(v(3, 8'h33, 8'hFF, 8'h00, 4'b1000, 3));
      // masked search and partial write
      tbl.push_back(v(1, 8'h02, 8'h0F, 8'h00, 4'b0100, 2));
      tbl.push_back(v(3, 8'hF0, 8'hF0, 8'h00, 4'b0100, 2));
      tbl.push_back(v(4, 8'h00, 8'h00, 8'hF2, 4'b0100, 2));
      // tag combine and resolution
      tbl.push_back(v(1, 8'h00, 8'h01, 8'h00, 4'b0101, 0));
      tbl.push_back(v(2, 8'h10, 8'hF0, 8'h00, 4'b0001, 0));
      tbl.push_back(v(6, 8'h00, 8'h00, 8'h00, 4'b1111, 0));
      tbl.push_back(v(5, 8'h00, 8'h00, 8'h00, 4'b0001, 0));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
      tbl.push_back(v(7, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
      tbl.push_back(v(4, 8'h00, 8'h00, 8'h00, 4'b0000, 0));
      // wired-OR read of 21 | 33
      tbl.push_back(v(1, 8'h01, 8'h01, 8'h00, 4'b1010, 1));
      tbl.push_back(v(4, 8'h00, 8'h00, 8'h33, 4'b1010, 1));
      tbl.push_back(v(0, 8'hFF, 8'hFF, 8'h00, 4'b1010, 1));

      for (int i = 0; i < 4; i++) mstore[i] = 8'h00;
      mtags = 4'b0000;

      repeat (3) @(negedge CLK);
      chk("reset.valid", rsp_valid, 0);
      chk("reset.data", rsp_data, 0);
      chk("reset.any", rsp_any, 0);
      chk("reset.first", rsp_first, 0);
      chk("reset.tags", tags, 0);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("reset.cmd_ready", cmd_ready, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         model(tbl[i].op, tbl[i].key, tbl[i].mask, e);
         e.data = tbl[i].data; e.tags = tbl[i].tags; e.any = tbl[i].any; e.first = tbl[i].first;
         send($sformatf("vec%0d", i), tbl[i].op, tbl[i].key, tbl[i].mask, i % 2, e);
      end

      // Backpressure: three commands back-to-back, response stalled for 4 cycles.
      model(3'd6, 8'h00, 8'h00, ea);
      model(3'd4, 8'h00, 8'h00, eb);
      model(3'd7, 8'h00, 8'h00, ec);
      @(negedge CLK);
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6;
      chk("bp.a_ready", cmd_ready, 1);
      @(posedge CLK);
      @(negedge CLK);
      cmd_op = 3'd4;
      chk_rsp("bp.a", ea);
      repeat (4) begin
         @(posedge CLK);
         @(negedge CLK);
         chk("bp.stall_ready", cmd_ready, 0);
         chk_rsp("bp.stall", ea);
      end
      rsp_ready = 1'b1;
      #1 chk("bp.release_ready", cmd_ready, 1);
      @(posedge CLK);
      @(negedge CLK);
      chk_rsp("bp.b", eb);
      cmd_op = 3'd7;
      @(posedge CLK);
      @(negedge CLK);
      chk_rsp("bp.c", ec);
      cmd_valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("bp.drained", rsp_valid, 0);

      for (int n = 0; n < 200; n++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: mask = 8'h00;
            1: mask = 8'hFF;
            default: mask = 8'($urandom);
         endcase
         key = ($urandom_range(0, 1) == 1) ? mstore[$urandom_range(0, 3)] : 8'($urandom);
         model(op, key, mask, e);
         send($sformatf("rnd%0d", n), op, key, mask, $urandom_range(0, 2), e);
      end

      // Reset with a response pending and a second command waiting.
      @(negedge CLK);
      rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd6;
      @(posedge CLK);
      @(negedge CLK);
      cmd_op = 3'd3; cmd_key = 8'h5A; cmd_mask = 8'hFF;
      chk("mid.pending", rsp_valid, 1);
      #2 RST_N = 1'b0;
      #1;
      chk("mid.valid", rsp_valid, 0);
      chk("mid.data", rsp_data, 0);
      chk("mid.any", rsp_any, 0);
      chk("mid.first", rsp_first, 0);
      chk("mid.tags", tags, 0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) mstore[i] = 8'h00;
      mtags = 4'b0000;
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("mid.no_stale_rsp", rsp_valid, 0);
      model(3'd6, 8'h00, 8'h00, e);
      send("post.set_all", 3'd6, 8'h00, 8'h00, 0, e);
      model(3'd4, 8'h00, 8'h00, e);
      chk("post.model_zero", {24'h0, e.data}, 0);
      send("post.read", 3'd4, 8'h00, 8'h00, 0, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end
endmodule
